wb_burst_mem_slave: RTL and testbench

// Wishbone B4 responder with on-chip byte-writable RAM. It serves as the far end of the DSP

---
 rtl/wb_burst_mem_slave_pkg.sv | 19 +
 rtl/wb_bytewe_ram.sv | 29 ++
 rtl/wb_burst_mem_slave.sv | 133 +++++++++++++
 tb/tb_wb_burst_mem_slave.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_burst_mem_slave_pkg.sv
// Shared Wishbone B4 cycle/burst encodings and the responder FSM state type.
// Pure declarations: no timing or flow control of its own.
package wb_burst_mem_slave_pkg;

  localparam logic [2:0] CTI_CONST  = 3'b001;
  localparam logic [2:0] CTI_INCR   = 3'b010;
  localparam logic [2:0] CTI_EOB    = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/wb_bytewe_ram.sv
// Single-port DEPTH x 32 synchronous RAM, per-byte write enables, read-first.
// One-cycle read latency; accepts an access every clock, never stalls.
module wb_bytewe_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    we,
  input  logic [AW-1:0] adr,
  input  logic [31:0]   wdat,
  output logic [31:0]   rdat
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (we[n]) mem[adr][8*n +: 8] <= wdat[8*n +: 8];
    end
  end

  // Only the output register is cleared; the array keeps its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdat <= '0;
    else        rdat <= mem[adr];
  end

endmodule

// File: rtl/wb_burst_mem_slave.sv
// Wishbone B4 RAM responder: classic cycles plus registered-feedback const/incr/wrap bursts.
// First ack one cycle after strobe, then one beat per clock; a stall or mismatch ends the burst.
module wb_burst_mem_slave
  import wb_burst_mem_slave_pkg::*;
#(
  parameter int            dw           = 32,
  parameter int            aw           = 32,
  parameter int            DEPTH        = 1024,
  parameter logic [aw-1:0] BASE_ADDRESS = '0
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int AW = $clog2(DEPTH);

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a,
                                        input logic [2:0]    cti,
                                        input logic [1:0]    bte);
    logic [AW-1:0] r;
    r = a;
    if (cti == CTI_INCR) begin
      case (bte)
        BTE_LINEAR: r      = a + AW'(1);
        BTE_WRAP4:  r[1:0] = a[1:0] + 2'd1;
        BTE_WRAP8:  r[2:0] = a[2:0] + 3'd1;
        BTE_WRAP16: r[3:0] = a[3:0] + 4'd1;
      endcase
    end
    return r;
  endfunction

  state_t        state;
  logic          ack_r;
  logic          err_r;
  logic [AW-1:0] beat_adr;

  logic [AW-1:0] word;
  logic [AW-1:0] nxt_beat;
  logic [AW-1:0] ram_adr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_q;
  logic          hit;
  logic          req;
  logic          beat_ok;
  logic          cont;
  logic          ack;
  logic          wr;
  logic          unused_adr;

  assign word       = wb_adr_i[AW+1:2];
  assign unused_adr = ^wb_adr_i[1:0];
  assign hit        = (wb_adr_i[aw-1:AW+2] == BASE_ADDRESS[aw-1:AW+2]);
  assign req        = wb_cyc_i & wb_stb_i & ~ack_r & ~err_r;

  // beat_adr is the word being acknowledged; the master must still be presenting it.
  assign beat_ok  = wb_cyc_i & wb_stb_i & hit & (word == beat_adr);
  assign cont     = beat_ok & (wb_cti_i != CTI_EOB);
  assign nxt_beat = nxt(beat_adr, wb_cti_i, wb_bte_i);

  assign ack     = ack_r & beat_ok;
  assign wr      = ack & wb_we_i;
  assign ram_we  = wr ? wb_sel_i : 4'b0000;
  assign ram_adr = wr ? beat_adr : ((state == ST_BURST) ? nxt_beat : word);

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state    <= ST_IDLE;
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      beat_adr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack_r <= 1'b0;
          err_r <= 1'b0;
          if (req) begin
            if (hit) begin
              ack_r    <= 1'b1;
              beat_adr <= word;
              if (wb_cti_i == CTI_CONST || wb_cti_i == CTI_INCR) state <= ST_BURST;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (cont) begin
            beat_adr <= nxt_beat;
          end else begin
            ack_r <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          ack_r <= 1'b0;
          err_r <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  wb_bytewe_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (wb_clk),
    .rst_n (wb_rst),
    .we    (ram_we),
    .adr   (ram_adr),
    .wdat  (wb_dat_i),
    .rdat  (ram_q)
  );

  assign wb_ack_o = ack;
  assign wb_err_o = err_r & wb_cyc_i & wb_stb_i;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = ack ? ram_q : '0;

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Directed bench for wb_burst_mem_slave with a reference memory and read-data scoreboard.
module tb_wb_burst_mem_slave;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model [1024];
  logic [31:0] exp_q [$];

  always #5 wb_clk = ~wb_clk;

  wb_burst_mem_slave dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_cti_i (wb_cti_i),
    .wb_bte_i (wb_bte_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .wb_rty_o (wb_rty_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Byte address of the following beat, computed as base-of-block | incremented offset.
  function automatic logic [31:0] tb_next(input logic [31:0] a, input logic [2:0] cti,
                                          input logic [1:0] bte);
    int unsigned w;
    int unsigned len;
    if (cti != 3'b010) return a;
    case (bte)
      2'b00:   len = 1024;
      2'b01:   len = 4;
      2'b10:   len = 8;
      default: len = 16;
    endcase
    w = 32'(a[11:2]);
    w = (w & ~(len - 1)) | ((w + 1) & (len - 1));
    return {a[31:12], w[9:0], 2'b00};
  endfunction

  function automatic logic [2:0] beat_cti(input logic [2:0] bcti, input int k, input int n);
    if (bcti == 3'b000) return 3'b000;
    return (k == n - 1) ? 3'b111 : bcti;
  endfunction

  task automatic bus_idle();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_cti_i = 3'b000; wb_bte_i = 2'b00; wb_sel_i = 4'h0;
    wb_adr_i = 32'h0; wb_dat_i = 32'h0;
  endtask

  task automatic present(input logic [31:0] a, input logic [2:0] cti, input logic [1:0] bte,
                         input logic we, input logic [3:0] sel, input logic [31:0] d);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = a; wb_cti_i = cti;
    wb_bte_i = bte;  wb_we_i = we;    wb_sel_i = sel; wb_dat_i = d;
    if (!we) exp_q.push_back(model[a[11:2]]);
  endtask

  // exp_cycles counts from the request cycle to the cycle of the last ack, inclusive.
  task automatic xfer(input string tag, input logic [31:0] adr0, input int n,
                      input logic [2:0] bcti, input logic [1:0] bte, input logic we,
                      input logic [3:0] sel, input logic [31:0] dbase,
                      input int stall_at, input int exp_cycles);
    logic [31:0] a;
    logic [31:0] exp;
    logic        done;
    int          k;
    int          cnt;
    a = adr0; k = 0; cnt = 0;
    present(a, beat_cti(bcti, k, n), bte, we, sel, dbase);
    while (k < n && cnt < 64) begin
      @(negedge wb_clk);
      cnt++;
      done = wb_ack_o;
      if (done) begin
        if (we) model[a[11:2]] = merge(model[a[11:2]], wb_dat_i, wb_sel_i);
        else begin
          exp = exp_q.pop_front();
          check({tag, " data"}, wb_dat_o, exp);
        end
      end
      @(posedge wb_clk); #1;
      if (done) begin
        k++;
        a = tb_next(a, bcti, bte);
        if (k == n) bus_idle();
        else begin
          if (k == stall_at) begin
            wb_stb_i = 1'b0;
            repeat (2) begin
              @(negedge wb_clk);
              cnt++;
              check({tag, " stall ack"}, 32'(wb_ack_o), 32'd0);
              @(posedge wb_clk); #1;
            end
          end
          present(a, beat_cti(bcti, k, n), bte, we, sel, dbase + 32'(k));
        end
      end
    end
    check({tag, " cycles"}, 32'(cnt), 32'(exp_cycles));
    bus_idle();
    exp_q.delete();
    @(negedge wb_clk);
    check({tag, " ack after"}, 32'(wb_ack_o), 32'd0);
    @(posedge wb_clk); #1;
  endtask

  task automatic oow(input string tag, input logic we);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h0000_1000; wb_we_i = we;
    wb_sel_i = 4'hF; wb_cti_i = 3'b000; wb_bte_i = 2'b00; wb_dat_i = 32'h5555_AAAA;
    @(negedge wb_clk);
    check({tag, " err early"}, 32'(wb_err_o), 32'd0);
    @(negedge wb_clk);
    check({tag, " err"}, 32'(wb_err_o), 32'd1);
    check({tag, " ack"}, 32'(wb_ack_o), 32'd0);
    check({tag, " dat"}, wb_dat_o, 32'd0);
    @(posedge wb_clk); #1;
    bus_idle();
    @(negedge wb_clk);
    check({tag, " err drop"}, 32'(wb_err_o), 32'd0);
    @(posedge wb_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp;

    // Reset with a live strobe: nothing may answer.
    bus_idle();
    wb_rst = 1'b0;
    repeat (2) @(posedge wb_clk);
    #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h10;
    @(posedge wb_clk);
    @(negedge wb_clk);
    check("rst ack", 32'(wb_ack_o), 32'd0);
    check("rst err", 32'(wb_err_o), 32'd0);
    check("rst rty", 32'(wb_rty_o), 32'd0);
    check("rst dat", wb_dat_o, 32'd0);
    @(posedge wb_clk); #1;
    bus_idle();
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;

    xfer("prefill",  32'h0000_0000, 16, 3'b010, 2'b00, 1'b1, 4'hF, 32'h1000_0000, -1, 17);
    xfer("fill_top", 32'h0000_0FFC,  1, 3'b000, 2'b00, 1'b1, 4'hF, 32'hCAFE_0FFC, -1, 2);

    xfer("t1_wr", 32'h10, 1, 3'b000, 2'b00, 1'b1, 4'hF, 32'hDEAD_BEEF, -1, 2);
    xfer("t1_rd", 32'h10, 1, 3'b000, 2'b00, 1'b0, 4'hF, 32'h0, -1, 2);

    xfer("t2_fill", 32'h20, 1, 3'b000, 2'b00, 1'b1, 4'hF, 32'hFFFF_FFFF, -1, 2);
    xfer("t2_wr",   32'h20, 1, 3'b000, 2'b00, 1'b1, 4'h5, 32'h1122_3344, -1, 2);
    xfer("t2_rd",   32'h20, 1, 3'b000, 2'b00, 1'b0, 4'hF, 32'h0, -1, 2);

    xfer("t3_incr8",  32'h00, 8, 3'b010, 2'b00, 1'b0, 4'hF, 32'h0, -1, 9);
    xfer("t4_wrap4",  32'h08, 4, 3'b010, 2'b01, 1'b0, 4'hF, 32'h0, -1, 5);
    xfer("t4_wrap8",  32'h18, 8, 3'b010, 2'b10, 1'b0, 4'hF, 32'h0, -1, 9);
    xfer("t4_wrap16", 32'h34, 16, 3'b010, 2'b11, 1'b0, 4'hF, 32'h0, -1, 17);
    xfer("t4_const",  32'h10, 3, 3'b001, 2'b00, 1'b0, 4'hF, 32'h0, -1, 4);
    xfer("t4_modwrap", 32'hFFC, 2, 3'b010, 2'b00, 1'b0, 4'hF, 32'h0, -1, 3);
    xfer("wr_wrap4",  32'h34, 4, 3'b010, 2'b01, 1'b1, 4'hF, 32'hB000_0000, -1, 5);
    xfer("rd_wrap4",  32'h30, 4, 3'b010, 2'b00, 1'b0, 4'hF, 32'h0, -1, 5);

    oow("t5_rd", 1'b0);
    oow("t5_wr", 1'b1);
    xfer("t5_alias", 32'h00, 1, 3'b000, 2'b00, 1'b0, 4'hF, 32'h0, -1, 2);

    xfer("t6_stall", 32'h00, 6, 3'b010, 2'b00, 1'b0, 4'hF, 32'h0, 3, 10);

    // Reset pulse while a read burst is in flight.
    present(32'h00, 3'b010, 2'b00, 1'b0, 4'hF, 32'h0);
    @(negedge wb_clk);
    @(negedge wb_clk);
    check("t6_rst beat0 ack", 32'(wb_ack_o), 32'd1);
    exp = exp_q.pop_front();
    check("t6_rst beat0 data", wb_dat_o, exp);
    @(posedge wb_clk); #1;
    present(32'h04, 3'b010, 2'b00, 1'b0, 4'hF, 32'h0);
    @(negedge wb_clk);
    check("t6_rst beat1 ack", 32'(wb_ack_o), 32'd1);
    exp = exp_q.pop_front();
    check("t6_rst beat1 data", wb_dat_o, exp);
    @(posedge wb_clk); #1;
    present(32'h08, 3'b010, 2'b00, 1'b0, 4'hF, 32'h0);
    #1 wb_rst = 1'b0;
    #1;
    check("t6_rst ack clear", 32'(wb_ack_o), 32'd0);
    check("t6_rst err clear", 32'(wb_err_o), 32'd0);
    exp_q.delete();
    @(posedge wb_clk); #1;
    bus_idle();
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    xfer("t6_post_rd", 32'h10, 1, 3'b000, 2'b00, 1'b0, 4'hF, 32'h0, -1, 2);

    // Reset asserted during the ack of a write: the word must keep its old value.
    xfer("t6_wfill", 32'h24, 1, 3'b000, 2'b00, 1'b1, 4'hF, 32'h0BAD_F00D, -1, 2);
    present(32'h24, 3'b000, 2'b00, 1'b1, 4'hF, 32'h1234_5678);
    @(negedge wb_clk);
    @(negedge wb_clk);
    check("t6_wr ack", 32'(wb_ack_o), 32'd1);
    #1 wb_rst = 1'b0;
    #1;
    check("t6_wr ack clear", 32'(wb_ack_o), 32'd0);
    @(posedge wb_clk); #1;
    bus_idle();
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    xfer("t6_wr_kept", 32'h24, 1, 3'b000, 2'b00, 1'b0, 4'hF, 32'h0, -1, 2);
    xfer("t6_final",   32'h10, 1, 3'b000, 2'b00, 1'b0, 4'hF, 32'h0, -1, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
